// File: rtl/alu_wide_pkg.sv
// Shared opcode codes and FSM state encoding for the alu_wide ALU.
package alu_wide_pkg;

  localparam logic [3:0] ALU_NOT = 4'h0;
  localparam logic [3:0] ALU_XOR = 4'h1;
  localparam logic [3:0] ALU_OR  = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_SUB = 4'h4;
  localparam logic [3:0] ALU_ADD = 4'h5;
  localparam logic [3:0] ALU_RR  = 4'h6;
  localparam logic [3:0] ALU_RL  = 4'h7;
  localparam logic [3:0] ALU_DEC = 4'h8;
  localparam logic [3:0] ALU_INC = 4'h9;
  localparam logic [3:0] ALU_ADC = 4'hA;
  localparam logic [3:0] ALU_SBB = 4'hB;
  localparam logic [3:0] ALU_CMP = 4'hC;
  localparam logic [3:0] ALU_MUL = 4'hD;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } alu_state_e;

endpackage

// File: rtl/alu_wide_mul.sv
// Shift-add unsigned multiplier: one partial-product step per busy cycle, WIDTH steps total.
module alu_wide_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             busy_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_lo_o,
  output logic [WIDTH-1:0] prod_hi_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] hi_step, lo_step;

  // lo holds the remaining multiplier bits; product bits shift in from the top.
  always_comb begin
    step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    hi_step  = step_sum[WIDTH:1];
    lo_step  = {step_sum[0], lo_q[WIDTH-1:1]};
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      mcand_d = a_i;
      hi_d    = '0;
      lo_d    = b_i;
      cnt_d   = '0;
    end else if (busy_i) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign done_o    = busy_i && (cnt_q == CntW'(WIDTH - 1));
  assign prod_lo_o = lo_step;
  assign prod_hi_o = hi_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_wide.sv
// Handshaked ALU with registered result and flags. Define ALU_MUL_EN to build the
// multi-cycle multiply; otherwise MUL behaves as a NOP.
module alu_wide
  import alu_wide_pkg::*;
#(
  parameter int unsigned           WIDTH      = 8,
  parameter logic [WIDTH-1:0]      RESULT_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_cy,
  output logic             flag_ov,
  output logic             flag_p,
  output logic             flag_s
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic z_q, z_d, cy_q, cy_d, ov_q, ov_d, p_q, p_d, s_q, s_d;
  logic out_valid_q, out_valid_d;

  logic             accept, mul_start, mul_done;
  logic [WIDTH-1:0] prod_lo, prod_hi;
  logic [WIDTH-1:0] opnd, alu_res;
  logic [WIDTH:0]   sum, diff;
  logic             cin, alu_cy, alu_ov, wr_res, wr_flags;

  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  alu_state_e state_q, state_d;

  assign in_ready  = (state_q == StIdle);
  assign mul_start = accept && (op == ALU_MUL);

  always_comb begin
    state_d = state_q;
    if (mul_start) begin
      state_d = StMul;
    end else if (mul_done) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  alu_wide_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .busy_i   (state_q == StMul),
    .a_i      (a),
    .b_i      (b),
    .done_o   (mul_done),
    .prod_lo_o(prod_lo),
    .prod_hi_o(prod_hi)
  );
`else
  assign in_ready  = 1'b1;
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign prod_lo   = '0;
  assign prod_hi   = '0;
`endif

  // Shared adder/subtractor; INC/DEC reuse it with an implicit operand of 1.
  always_comb begin
    opnd = ((op == ALU_INC) || (op == ALU_DEC)) ? WIDTH'(1) : b;
    cin  = ((op == ALU_ADC) || (op == ALU_SBB)) ? cy_q : 1'b0;
    sum  = {1'b0, a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
    diff = {1'b0, a} - {1'b0, opnd} - {{WIDTH{1'b0}}, cin};

    alu_res  = result_q;
    alu_cy   = cy_q;
    alu_ov   = ov_q;
    wr_res   = 1'b1;
    wr_flags = 1'b1;
    case (op)
      ALU_NOT: alu_res = ~a;
      ALU_XOR: alu_res = a ^ b;
      ALU_OR:  alu_res = a | b;
      ALU_AND: alu_res = a & b;
      ALU_ADD, ALU_ADC, ALU_INC: begin
        alu_res = sum[Msb:0];
        alu_cy  = sum[WIDTH];
        alu_ov  = (a[Msb] == opnd[Msb]) && (sum[Msb] != a[Msb]);
      end
      ALU_SUB, ALU_SBB, ALU_DEC, ALU_CMP: begin
        alu_res = diff[Msb:0];
        alu_cy  = diff[WIDTH];
        alu_ov  = (a[Msb] != opnd[Msb]) && (diff[Msb] != a[Msb]);
        wr_res  = (op != ALU_CMP);
      end
      ALU_RR: begin
        alu_res = {1'b0, a[Msb:1]};
        alu_cy  = a[0];
        alu_ov  = 1'b0;
      end
      ALU_RL: begin
        alu_res = {a[Msb-1:0], 1'b0};
        alu_cy  = a[Msb];
        alu_ov  = 1'b0;
      end
      default: begin
        wr_res   = 1'b0;
        wr_flags = 1'b0;
      end
    endcase
  end

  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    z_d         = z_q;
    cy_d        = cy_q;
    ov_d        = ov_q;
    p_d         = p_q;
    s_d         = s_q;
    out_valid_d = 1'b0;
    if (accept && !mul_start) begin
      out_valid_d = 1'b1;
      result_hi_d = '0;
      if (wr_res) begin
        result_d = alu_res;
      end
      if (wr_flags) begin
        z_d  = (alu_res == '0);
        cy_d = alu_cy;
        ov_d = alu_ov;
        p_d  = ~^alu_res;
        s_d  = alu_res[Msb];
      end
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = prod_lo;
      result_hi_d = prod_hi;
      z_d         = (prod_lo == '0);
      cy_d        = |prod_hi;
      ov_d        = |prod_hi;
      p_d         = ~^prod_lo;
      s_d         = prod_lo[Msb];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= RESULT_RST;
      result_hi_q <= '0;
      z_q         <= 1'b0;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
      p_q         <= 1'b0;
      s_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      z_q         <= z_d;
      cy_q        <= cy_d;
      ov_q        <= ov_d;
      p_q         <= p_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign out_valid = out_valid_q;
  assign flag_z    = z_q;
  assign flag_cy   = cy_q;
  assign flag_ov   = ov_q;
  assign flag_p    = p_q;
  assign flag_s    = s_q;

endmodule

// File: tb/tb_alu_wide.sv
// Directed self-checking bench for alu_wide (8-bit instance plus a 16-bit instance).
module tb_alu_wide;
  import alu_wide_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] op = 4'h0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic in_ready, out_valid, flag_z, flag_cy, flag_ov, flag_p, flag_s;
  logic [7:0] result, result_hi;

  logic in_valid16 = 1'b0;
  logic [3:0] op16 = 4'h0;
  logic [15:0] a16 = 16'h0, b16 = 16'h0;
  logic in_ready16, out_valid16, z16, cy16, ov16, p16, s16;
  logic [15:0] result16, result_hi16;

  int n_checks = 0;
  int n_fail = 0;

  // {Z, CY, OV, P, S}
  wire [4:0] flags = {flag_z, flag_cy, flag_ov, flag_p, flag_s};

  always #5 clk = ~clk;

  alu_wide #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .result_hi(result_hi), .flag_z(flag_z),
    .flag_cy(flag_cy), .flag_ov(flag_ov), .flag_p(flag_p), .flag_s(flag_s)
  );

  alu_wide #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16), .a(a16),
    .b(b16), .out_valid(out_valid16), .result(result16), .result_hi(result_hi16),
    .flag_z(z16), .flag_cy(cy16), .flag_ov(ov16), .flag_p(p16), .flag_s(s16)
  );

  // Presents one request for one cycle; returns at the negedge after acceptance.
  task automatic drive(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drive16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    in_valid16 = 1'b1; op16 = o; a16 = x; b16 = y;
    @(negedge clk);
    in_valid16 = 1'b0;
  endtask

  task automatic test_reset;
    drive(ALU_ADD, 8'h12, 8'h34);
    n_checks++;
    if (result !== 8'h46) begin
      n_fail++; $display("FAIL pre_reset_add: got %h want 46", result);
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; op = ALU_ADD; a = 8'h01; b = 8'h01;
    #1;
    n_checks++;
    if ({result, result_hi, flags, in_ready, out_valid} !== {8'h00, 8'h00, 5'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: res=%h hi=%h flags=%b rdy=%b ov=%b want 00 00 00000 1 0",
               result, result_hi, flags, in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, result, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_idle: ov=%b res=%h rdy=%b want 0 00 1", out_valid, result, in_ready);
    end
  endtask

  task automatic test_add_adc;
    drive(ALU_ADD, 8'hFF, 8'h01);
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, 8'h00, 5'b11010}) begin
      n_fail++;
      $display("FAIL add_ff_01: ov=%b res=%h flags=%b want 1 00 11010", out_valid, result, flags);
    end
    drive(ALU_ADC, 8'h00, 8'h00);
    n_checks++;
    if ({result, flags} !== {8'h01, 5'b00000}) begin
      n_fail++; $display("FAIL adc_carry_in: res=%h flags=%b want 01 00000", result, flags);
    end
  endtask

  task automatic test_sub_cmp;
    drive(ALU_SUB, 8'h80, 8'h01);
    n_checks++;
    if ({result, flags} !== {8'h7F, 5'b00100}) begin
      n_fail++; $display("FAIL sub_80_01: res=%h flags=%b want 7f 00100", result, flags);
    end
    drive(ALU_CMP, 8'h01, 8'h02);
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, 8'h7F, 5'b01011}) begin
      n_fail++;
      $display("FAIL cmp_01_02: ov=%b res=%h flags=%b want 1 7f 01011", out_valid, result, flags);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; op = ALU_INC; a = 8'h7F; b = 8'h00;
    @(negedge clk);
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, 8'h80, 5'b00101}) begin
      n_fail++; $display("FAIL b2b_inc: ov=%b res=%h flags=%b want 1 80 00101", out_valid, result, flags);
    end
    op = ALU_DEC; a = 8'h00;
    @(negedge clk);
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, 8'hFF, 5'b01011}) begin
      n_fail++; $display("FAIL b2b_dec: ov=%b res=%h flags=%b want 1 ff 01011", out_valid, result, flags);
    end
    op = ALU_RR; a = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, result, flags} !== {1'b1, 8'h00, 5'b11010}) begin
      n_fail++; $display("FAIL b2b_rr: ov=%b res=%h flags=%b want 1 00 11010", out_valid, result, flags);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_logic_shift;
    drive(ALU_XOR, 8'hF0, 8'hFF);
    n_checks++;
    if ({result, flags} !== {8'h0F, 5'b01010}) begin
      n_fail++; $display("FAIL xor_keeps_cy: res=%h flags=%b want 0f 01010", result, flags);
    end
    drive(ALU_NOT, 8'h0F, 8'h00);
    n_checks++;
    if ({result, flags} !== {8'hF0, 5'b01011}) begin
      n_fail++; $display("FAIL not: res=%h flags=%b want f0 01011", result, flags);
    end
    drive(ALU_AND, 8'hF0, 8'h3C);
    n_checks++;
    if ({result, flags} !== {8'h30, 5'b01010}) begin
      n_fail++; $display("FAIL and: res=%h flags=%b want 30 01010", result, flags);
    end
    drive(ALU_RL, 8'h81, 8'h00);
    n_checks++;
    if ({result, flags} !== {8'h02, 5'b01000}) begin
      n_fail++; $display("FAIL rl_81: res=%h flags=%b want 02 01000", result, flags);
    end
    drive(ALU_SBB, 8'h05, 8'h02);
    n_checks++;
    if ({result, flags} !== {8'h02, 5'b00000}) begin
      n_fail++; $display("FAIL sbb_borrow_in: res=%h flags=%b want 02 00000", result, flags);
    end
    drive(ALU_OR, 8'h5A, 8'h00);
    n_checks++;
    if ({result, flags} !== {8'h5A, 5'b00010}) begin
      n_fail++; $display("FAIL or_5a: res=%h flags=%b want 5a 00010", result, flags);
    end
  endtask

  task automatic test_nop;
    drive(4'hE, 8'hFF, 8'hFF);
    n_checks++;
    if ({out_valid, result, result_hi, flags} !== {1'b1, 8'h5A, 8'h00, 5'b00010}) begin
      n_fail++;
      $display("FAIL nop_hold: ov=%b res=%h hi=%h flags=%b want 1 5a 00 00010",
               out_valid, result, result_hi, flags);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul;
    int busy_bad;
    busy_bad = 0;
    drive(ALU_MUL, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++; $display("FAIL mul_busy: %0d bad busy cycles want 0", busy_bad);
    end
    n_checks++;
    if ({out_valid, result, result_hi, flags} !== {1'b1, 8'h01, 8'hFE, 5'b01100}) begin
      n_fail++;
      $display("FAIL mul_ff_ff: ov=%b res=%h hi=%h flags=%b want 1 01 fe 01100",
               out_valid, result, result_hi, flags);
    end
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL mul_after: rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    // Abort on the 4th busy cycle.
    drive(ALU_MUL, 8'h03, 8'h04);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL mul_abort_rst: rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    busy_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) busy_bad++;
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++; $display("FAIL mul_abort_quiet: %0d bad cycles want 0", busy_bad);
    end
  endtask
`else
  task automatic test_mul;
    drive(ALU_MUL, 8'h03, 8'h04);
    n_checks++;
    if ({out_valid, in_ready, result, result_hi, flags} !==
        {1'b1, 1'b1, 8'h5A, 8'h00, 5'b00010}) begin
      n_fail++;
      $display("FAIL mul_as_nop: ov=%b rdy=%b res=%h hi=%h flags=%b want 1 1 5a 00 00010",
               out_valid, in_ready, result, result_hi, flags);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mul_nop_pulse: out_valid=%b want 0", out_valid);
    end
  endtask
`endif

  task automatic test_wide16;
    drive16(ALU_ADD, 16'hFFFF, 16'h0001);
    n_checks++;
    if ({out_valid16, result16, z16, cy16, ov16} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL w16_add: ov=%b res=%h z=%b cy=%b ovf=%b want 1 0000 1 1 0",
               out_valid16, result16, z16, cy16, ov16);
    end
    drive16(ALU_ADC, 16'h0000, 16'h0000);
    n_checks++;
    if ({result16, z16, cy16} !== {16'h0001, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL w16_adc: res=%h z=%b cy=%b want 0001 0 0", result16, z16, cy16);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_add_adc();
    test_sub_cmp();
    test_back_to_back();
    test_logic_shift();
    test_nop();
    test_mul();
    test_wide16();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
